// File: rtl/arbiter_wrr.sv
// arbiter_wrr: weighted round-robin, frame-aware grant controller for a shared
// AXI-Stream datapath. One requester is granted at a time, the grant is held for
// whole frames, and each owner may send up to max(weight,1) consecutive frames
// per turn before the grant rotates.
//
// Optional feature: define ARBITER_WRR_WATCHDOG_EN to add the TIMEOUT parameter
// and the timeout port. This forces a release when the owner stalls without a beat.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   request        per-port request level
//   weight         per-port frames-per-turn, port i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   beat           transfer of the granted stream completed (tvalid & tready)
//   last           tlast of the granted stream, qualified by beat
//   grant          registered one-hot grant
//   grant_valid    grant is nonzero
//   grant_encoded  index of granted port, 0 when idle
//   timeout        one-cycle pulse after a forced release (watchdog build only)
module arbiter_wrr #(
    parameter int unsigned PORTS        = 4,
    parameter int unsigned WEIGHT_WIDTH = 4,
`ifdef ARBITER_WRR_WATCHDOG_EN
    parameter int unsigned TIMEOUT      = 1024,
`endif
    localparam int unsigned IDX_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORTS-1:0]                request,
    input  logic [PORTS*WEIGHT_WIDTH-1:0]   weight,
    input  logic                            beat,
    input  logic                            last,
    output logic [PORTS-1:0]                grant,
    output logic                            grant_valid,
    output logic [IDX_W-1:0]                grant_encoded
`ifdef ARBITER_WRR_WATCHDOG_EN
    ,
    output logic                            timeout
`endif
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t                   state, state_n;
    logic [IDX_W-1:0]         ptr, ptr_n;
    logic [WEIGHT_WIDTH-1:0]  credit, credit_n;
    logic [PORTS-1:0]         grant_n;
    logic                     grant_valid_n;
    logic [IDX_W-1:0]         grant_encoded_n;

    logic [WEIGHT_WIDTH-1:0]  w_arr [PORTS];
    logic                     found;
    logic [IDX_W-1:0]         pick;
    logic                     rearb;
    logic                     frame_end;
    logic                     force_rel;

    // Per-port weight slices.
    for (genvar gi = 0; gi < PORTS; gi++) begin : g_w
        assign w_arr[gi] = weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

`ifdef ARBITER_WRR_WATCHDOG_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wd_cnt, wd_cnt_n;
    logic             timeout_n;

    assign force_rel = (state == S_GRANT) && (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign force_rel = 1'b0;
`endif

    assign frame_end = (state == S_GRANT) && beat && last;

    // First requester after ptr, wrapping; ptr itself is searched last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 1; k <= PORTS; k++) begin
            logic [IDX_W-1:0] sel;
            sel = IDX_W'((32'(ptr) + k) % PORTS);
            if (!found && request[sel]) begin
                found = 1'b1;
                pick  = sel;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n         = state;
        ptr_n           = ptr;
        credit_n        = credit;
        grant_n         = grant;
        grant_valid_n   = grant_valid;
        grant_encoded_n = grant_encoded;
        rearb           = 1'b0;

        case (state)
            S_IDLE: begin
                if (|request) rearb = 1'b1;
            end
            S_GRANT: begin
                if (force_rel) begin
                    rearb = 1'b1;
                end else if (frame_end) begin
                    // Hold while credit remains after this frame and owner still requests.
                    if ((credit > WEIGHT_WIDTH'(1)) && request[ptr])
                        credit_n = credit - WEIGHT_WIDTH'(1);
                    else
                        rearb = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (rearb) begin
            if (found) begin
                state_n         = S_GRANT;
                ptr_n           = pick;
                credit_n        = (w_arr[pick] == '0) ? WEIGHT_WIDTH'(1) : w_arr[pick];
                grant_n         = PORTS'(1) << pick;
                grant_valid_n   = 1'b1;
                grant_encoded_n = pick;
            end else begin
                state_n         = S_IDLE;
                credit_n        = '0;
                grant_n         = '0;
                grant_valid_n   = 1'b0;
                grant_encoded_n = '0;
            end
        end
    end

`ifdef ARBITER_WRR_WATCHDOG_EN
    // Stall counter: cleared by any beat or new grant, counts idle owner cycles.
    always_comb begin
        wd_cnt_n  = '0;
        timeout_n = force_rel;
        if ((state == S_GRANT) && !beat && !rearb)
            wd_cnt_n = wd_cnt + CNT_W'(1);
    end
`endif

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            ptr           <= IDX_W'(PORTS - 1);
            credit        <= '0;
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_encoded <= '0;
`ifdef ARBITER_WRR_WATCHDOG_EN
            wd_cnt        <= '0;
            timeout       <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            credit        <= credit_n;
            grant         <= grant_n;
            grant_valid   <= grant_valid_n;
            grant_encoded <= grant_encoded_n;
`ifdef ARBITER_WRR_WATCHDOG_EN
            wd_cnt        <= wd_cnt_n;
            timeout       <= timeout_n;
`endif
        end
    end

endmodule

// File: tb/tb_arbiter_wrr.sv
// tb_arbiter_wrr: directed scoreboard bench for arbiter_wrr (PORTS=4, WEIGHT_WIDTH=4).
// The driver pushes the expected post-edge outputs for every cycle it drives;
// the monitor pops and compares them shortly after each rising edge.
module tb_arbiter_wrr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  request = 4'b0000;
    logic [15:0] weight = 16'h1111;
    logic        beat = 1'b0;
    logic        last = 1'b0;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [1:0]  grant_encoded;
`ifdef ARBITER_WRR_WATCHDOG_EN
    logic        timeout;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] q_exp [$];
    string      q_name [$];

    logic [4:0] m_exp;
    string      m_name;
    logic       m_tout;
    logic [1:0] m_enc;
    logic       m_ok;

    always #5 clk = ~clk;

    arbiter_wrr #(
        .PORTS        (4),
        .WEIGHT_WIDTH (4)
`ifdef ARBITER_WRR_WATCHDOG_EN
        ,
        .TIMEOUT      (8)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .request       (request),
        .weight        (weight),
        .beat          (beat),
        .last          (last),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_encoded (grant_encoded)
`ifdef ARBITER_WRR_WATCHDOG_EN
        ,
        .timeout       (timeout)
`endif
    );

    function automatic logic [1:0] onehot_idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = 2'(i);
        return r;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic cyc(input logic r, input logic [3:0] req, input logic b, input logic l,
                       input logic [3:0] eg, input logic et, input string nm);
        @(negedge clk);
        rst     = r;
        request = req;
        beat    = b;
        last    = l;
        q_exp.push_back({et, eg});
        q_name.push_back(nm);
    endtask

    // Monitor: compare registered outputs against the scoreboard.
    always @(posedge clk) begin
        #1;
        if (q_exp.size() > 0) begin
            m_exp  = q_exp.pop_front();
            m_name = q_name.pop_front();
`ifdef ARBITER_WRR_WATCHDOG_EN
            m_tout = timeout;
`else
            m_tout = 1'b0;
`endif
            m_enc = onehot_idx(m_exp[3:0]);
            m_ok  = (grant === m_exp[3:0]) && (grant_valid === (|m_exp[3:0])) &&
                    (grant_encoded === m_enc) && (m_tout === m_exp[4]);
            n_checks++;
            if (m_ok)
                n_pass++;
            else
                $display("FAIL %s: got grant=%b valid=%b enc=%0d timeout=%b, expected grant=%b valid=%b enc=%0d timeout=%b",
                         m_name, grant, grant_valid, grant_encoded, m_tout,
                         m_exp[3:0], |m_exp[3:0], m_enc, m_exp[4]);
        end
    end

    initial begin
        // Reset
        cyc(1, 4'b0000, 0, 0, 4'b0000, 0, "reset0");
        cyc(1, 4'b0101, 1, 1, 4'b0000, 0, "reset1");

        // Basic rotation, weights all 1
        weight = 16'h1111;
        cyc(0, 4'b0101, 0, 0, 4'b0001, 0, "t1_first");
        cyc(0, 4'b0101, 1, 1, 4'b0100, 0, "t1_rot2");
        cyc(0, 4'b0101, 1, 1, 4'b0001, 0, "t1_rot0");
        cyc(0, 4'b0000, 1, 1, 4'b0000, 0, "t1_idle");

        // Port 1 weight 3, single-beat frames; beat/last in IDLE ignored
        weight = 16'h1131;
        cyc(0, 4'b0011, 1, 1, 4'b0010, 0, "t2_g1a");
        cyc(0, 4'b0011, 1, 1, 4'b0010, 0, "t2_g1b");
        cyc(0, 4'b0011, 1, 1, 4'b0010, 0, "t2_g1c");
        cyc(0, 4'b0011, 1, 1, 4'b0001, 0, "t2_g0");
        cyc(0, 4'b0011, 1, 1, 4'b0010, 0, "t2_g1d");
        cyc(0, 4'b0000, 1, 1, 4'b0000, 0, "t2_idle");

        // Weight 0 behaves as 1
        weight = 16'h1101;
        cyc(0, 4'b0010, 0, 0, 4'b0010, 0, "t2w0_g1");
        cyc(0, 4'b0011, 1, 1, 4'b0001, 0, "t2w0_g0");
        cyc(0, 4'b0000, 1, 1, 4'b0000, 0, "t2w0_idle");

        // Owner drops request mid-frame; port 0 has spare credit but must release
        weight = 16'h1112;
        cyc(0, 4'b0001, 0, 0, 4'b0001, 0, "t3_grant");
        cyc(0, 4'b0001, 1, 0, 4'b0001, 0, "t3_b1");
        cyc(0, 4'b0000, 1, 0, 4'b0001, 0, "t3_b2_drop");
        cyc(0, 4'b0000, 1, 0, 4'b0001, 0, "t3_b3");
        cyc(0, 4'b0000, 1, 0, 4'b0001, 0, "t3_b4");
        cyc(0, 4'b0000, 1, 1, 4'b0000, 0, "t3_last_idle");

        // Reset mid-frame, then fresh priority from port 0
        weight = 16'h1111;
        cyc(0, 4'b0010, 0, 0, 4'b0010, 0, "t5_grant");
        cyc(0, 4'b0010, 1, 0, 4'b0010, 0, "t5_b1");
        cyc(0, 4'b0010, 1, 0, 4'b0010, 0, "t5_b2");
        cyc(1, 4'b0010, 1, 1, 4'b0000, 0, "t5_rst_b3");
        cyc(0, 4'b1000, 0, 0, 4'b1000, 0, "t5_g3");

        // Back-to-back single-beat frames, all requesting
        cyc(0, 4'b1111, 1, 1, 4'b0001, 0, "t4_r0");
        cyc(0, 4'b1111, 1, 1, 4'b0010, 0, "t4_r1");
        cyc(0, 4'b1111, 1, 1, 4'b0100, 0, "t4_r2");
        cyc(0, 4'b1111, 1, 1, 4'b1000, 0, "t4_r3");
        cyc(0, 4'b1111, 1, 1, 4'b0001, 0, "t4_r0b");
        cyc(0, 4'b0000, 1, 1, 4'b0000, 0, "t4_idle");

`ifdef ARBITER_WRR_WATCHDOG_EN
        // Watchdog, TIMEOUT=8: stall on port 0, then beat-reset of the count on port 1
        cyc(0, 4'b0001, 0, 0, 4'b0001, 0, "wd_grant0");
        for (int k = 1; k <= 21; k++) begin
            logic [3:0] eg;
            logic       et;
            logic       b;
            eg = (k <= 7) ? 4'b0001 : ((k <= 20) ? 4'b0010 : 4'b0001);
            et = (k == 8) || (k == 21);
            b  = (k == 13);
            cyc(0, 4'b0011, b, 0, eg, et, $sformatf("wd_k%0d", k));
        end
        cyc(0, 4'b0000, 1, 1, 4'b0000, 0, "wd_release");
`endif

        // Let the monitor drain the last expectation
        @(negedge clk);
        rst = 1'b0; request = 4'b0000; beat = 1'b0; last = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        if (q_exp.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", q_exp.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
